// File: rtl/cis_line_sequencer.sv
// Line-timing sequencer for contact image sensors: SI start pulse, per-channel LED
// exposure windows and line/group framing across a masked set of colour channels.
module cis_line_sequencer #(
  parameter int NCH          = 3,
  parameter int LINE_TIME    = 2688,
  parameter int PIX_CNT      = 2592,
  parameter int LED_ON_START = 60,
  parameter int SI_WIDTH     = 5,
  parameter int CNT_WIDTH    = 24,
  parameter int LCNT_WIDTH   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            MODE,
  input  logic [NCH-1:0]        CH_MASK,
  input  logic [CNT_WIDTH-1:0]  GROUP_DELAY,
  input  logic                  EXT_START,
  input  logic [LCNT_WIDTH-1:0] EXT_LCNT,
  output logic                  SI,
  output logic [NCH-1:0]        LED_EN,
  output logic [2:0]            CH_IDX,
  output logic                  LINE_START,
  output logic                  GROUP_DONE,
  output logic                  BUSY,
  output logic                  TRIG_MISSED
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LINE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  LT_C      = CNT_WIDTH'(LINE_TIME);
  localparam logic [CNT_WIDTH-1:0]  LAST_LC   = CNT_WIDTH'(LINE_TIME - 1);
  localparam logic [CNT_WIDTH-1:0]  SI_END    = CNT_WIDTH'(SI_WIDTH);
  localparam logic [CNT_WIDTH-1:0]  LED_ON    = CNT_WIDTH'(LED_ON_START);
  localparam logic [CNT_WIDTH-1:0]  LED_OFF   = CNT_WIDTH'(LED_ON_START + PIX_CNT);
  localparam logic [LCNT_WIDTH-1:0] LCNT_ZERO = {LCNT_WIDTH{1'b0}};
  localparam logic [LCNT_WIDTH-1:0] LCNT_ONE  = {{(LCNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [NCH-1:0] eff_mask(input logic [NCH-1:0] m);
    eff_mask = (m == {NCH{1'b0}}) ? {NCH{1'b1}} : m;
  endfunction

  function automatic logic [2:0] lowest_idx(input logic [NCH-1:0] m);
    lowest_idx = 3'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = 3'(i);
    end
  endfunction

  // Bit 3 flags that a higher-indexed enabled channel exists; bits 2:0 give its index.
  function automatic logic [3:0] next_idx(input logic [NCH-1:0] m, input logic [2:0] cur);
    next_idx = 4'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && (3'(i) > cur)) next_idx = {1'b1, 3'(i)};
    end
  endfunction

  function automatic logic [NCH-1:0] onehot(input logic [2:0] idx);
    for (int i = 0; i < NCH; i++) begin
      onehot[i] = (idx == 3'(i));
    end
  endfunction

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  lc_q, lc_d;
  logic [CNT_WIDTH-1:0]  gc_q, gc_d;
  logic [LCNT_WIDTH-1:0] gcount_q, gcount_d;
  logic [2:0]            ch_q, ch_d;
  logic [1:0]            mode_q, mode_d;
  logic [NCH-1:0]        mask_q, mask_d;
  logic [CNT_WIDTH-1:0]  dly_q, dly_d;
  logic [LCNT_WIDTH-1:0] lcnt_q, lcnt_d;
  logic                  start_q, start_d;
  logic                  ext1_q, ext1_d;
  logic                  ext2_q, ext2_d;

  logic                  si_q, si_d;
  logic [NCH-1:0]        led_q, led_d;
  logic [2:0]            ch_out_q, ch_out_d;
  logic                  ls_q, ls_d;
  logic                  gd_q, gd_d;
  logic                  busy_q, busy_d;
  logic                  tm_q, tm_d;

  logic                  rise_s;
  logic                  go_s;
  logic                  do_start_s;
  logic [NCH-1:0]        gs_mask_s;
  logic [CNT_WIDTH-1:0]  gs_dly_s;
  logic [LCNT_WIDTH-1:0] gs_lcnt_s;
  logic [3:0]            nx_s;
  logic [CNT_WIDTH-1:0]  gap_last_s;
  logic [LCNT_WIDTH-1:0] gcount_inc_s;

  // Sequencer next-state: line/gap counters, channel stepping and group-start capture.
  always_comb begin
    state_d    = state_q;
    lc_d       = lc_q;
    gc_d       = gc_q;
    gcount_d   = gcount_q;
    ch_d       = ch_q;
    start_d    = 1'b0;
    ext1_d     = EXT_START;
    ext2_d     = ext1_q;
    do_start_s = 1'b0;

    rise_s       = ext1_q & ~ext2_q;
    go_s         = (MODE == 2'd0) || (MODE == 2'd1) || ((MODE == 2'd2) && rise_s);
    gs_mask_s    = eff_mask(CH_MASK);
    gs_dly_s     = (GROUP_DELAY < LT_C) ? LT_C : GROUP_DELAY;
    gs_lcnt_s    = (EXT_LCNT == LCNT_ZERO) ? LCNT_ONE : EXT_LCNT;
    nx_s         = next_idx(mask_q, ch_q);
    gap_last_s   = (mode_q == 2'd1) ? (dly_q - CNT_ONE) : LAST_LC;
    gcount_inc_s = gcount_q + LCNT_ONE;

    case (state_q)
      ST_IDLE: begin
        ch_d = lowest_idx(gs_mask_s);
        if (start_q) begin
          do_start_s = 1'b1;
        end else begin
          start_d = go_s;
        end
      end
      ST_LINE: begin
        if (lc_q != LAST_LC) begin
          lc_d = lc_q + CNT_ONE;
        end else if (nx_s[3]) begin
          ch_d = nx_s[2:0];
          lc_d = CNT_ZERO;
        end else begin
          lc_d = CNT_ZERO;
          case (mode_q)
            2'd0: do_start_s = 1'b1;
            2'd1: begin
              state_d = ST_GAP;
              gc_d    = CNT_ZERO;
            end
            2'd2: begin
              if (gcount_inc_s == lcnt_q) begin
                gcount_d = LCNT_ZERO;
                state_d  = ST_GAP;
                gc_d     = CNT_ZERO;
              end else begin
                gcount_d   = gcount_inc_s;
                do_start_s = 1'b1;
              end
            end
            default: begin
              state_d = ST_IDLE;
              ch_d    = lowest_idx(gs_mask_s);
            end
          endcase
        end
      end
      ST_GAP: begin
        if (gc_q != gap_last_s) begin
          gc_d = gc_q + CNT_ONE;
        end else if (mode_q == 2'd1) begin
          gc_d       = CNT_ZERO;
          do_start_s = 1'b1;
        end else begin
          gc_d    = CNT_ZERO;
          state_d = ST_IDLE;
          ch_d    = lowest_idx(gs_mask_s);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Group configuration is only sampled here, so mid-group input changes wait.
    if (do_start_s) begin
      state_d  = ST_LINE;
      lc_d     = CNT_ZERO;
      mode_d   = MODE;
      mask_d   = gs_mask_s;
      dly_d    = gs_dly_s;
      lcnt_d   = gs_lcnt_s;
      ch_d     = lowest_idx(gs_mask_s);
      gcount_d = (MODE == 2'd2) ? gcount_d : LCNT_ZERO;
    end else begin
      mode_d   = mode_q;
      mask_d   = mask_q;
      dly_d    = dly_q;
      lcnt_d   = lcnt_q;
    end
  end

  // Output decode from the current sequencer state; registered below.
  always_comb begin
    si_d     = ((state_q == ST_LINE) && (lc_q < SI_END)) ||
               ((state_q == ST_GAP) && (gc_q < SI_END));
    led_d    = ((state_q == ST_LINE) && (lc_q >= LED_ON) && (lc_q < LED_OFF)) ?
               onehot(ch_q) : {NCH{1'b0}};
    ls_d     = (state_q == ST_LINE) && (lc_q == CNT_ZERO);
    gd_d     = (state_q == ST_LINE) && (lc_q == LAST_LC) && !nx_s[3];
    busy_d   = (state_q != ST_IDLE);
    tm_d     = rise_s && ((state_q != ST_IDLE) || (MODE != 2'd2));
    ch_out_d = ch_q;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      lc_q     <= CNT_ZERO;
      gc_q     <= CNT_ZERO;
      gcount_q <= LCNT_ZERO;
      ch_q     <= 3'd0;
      mode_q   <= 2'd0;
      mask_q   <= {NCH{1'b1}};
      dly_q    <= LT_C;
      lcnt_q   <= LCNT_ONE;
      start_q  <= 1'b0;
      ext1_q   <= 1'b0;
      ext2_q   <= 1'b0;
      si_q     <= 1'b0;
      led_q    <= {NCH{1'b0}};
      ch_out_q <= 3'd0;
      ls_q     <= 1'b0;
      gd_q     <= 1'b0;
      busy_q   <= 1'b0;
      tm_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      lc_q     <= lc_d;
      gc_q     <= gc_d;
      gcount_q <= gcount_d;
      ch_q     <= ch_d;
      mode_q   <= mode_d;
      mask_q   <= mask_d;
      dly_q    <= dly_d;
      lcnt_q   <= lcnt_d;
      start_q  <= start_d;
      ext1_q   <= ext1_d;
      ext2_q   <= ext2_d;
      si_q     <= si_d;
      led_q    <= led_d;
      ch_out_q <= ch_out_d;
      ls_q     <= ls_d;
      gd_q     <= gd_d;
      busy_q   <= busy_d;
      tm_q     <= tm_d;
    end
  end

  assign SI          = si_q;
  assign LED_EN      = led_q;
  assign CH_IDX      = ch_out_q;
  assign LINE_START  = ls_q;
  assign GROUP_DONE  = gd_q;
  assign BUSY        = busy_q;
  assign TRIG_MISSED = tm_q;

endmodule

// File: tb/tb_cis_line_sequencer.sv
// Directed bench for cis_line_sequencer with small timing parameters; t counts
// negedge samples relative to the first SI/LINE_START after each reset release.
module tb_cis_line_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  MODE;
  logic [2:0]  CH_MASK;
  logic [23:0] GROUP_DELAY;
  logic        EXT_START;
  logic [15:0] EXT_LCNT;
  logic        SI;
  logic [2:0]  LED_EN;
  logic [2:0]  CH_IDX;
  logic        LINE_START;
  logic        GROUP_DONE;
  logic        BUSY;
  logic        TRIG_MISSED;

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;

  cis_line_sequencer #(
    .NCH(3), .LINE_TIME(40), .PIX_CNT(20), .LED_ON_START(10),
    .SI_WIDTH(3), .CNT_WIDTH(24), .LCNT_WIDTH(16)
  ) dut (
    .CLK(CLK), .RST(RST), .MODE(MODE), .CH_MASK(CH_MASK),
    .GROUP_DELAY(GROUP_DELAY), .EXT_START(EXT_START), .EXT_LCNT(EXT_LCNT),
    .SI(SI), .LED_EN(LED_EN), .CH_IDX(CH_IDX), .LINE_START(LINE_START),
    .GROUP_DONE(GROUP_DONE), .BUSY(BUSY), .TRIG_MISSED(TRIG_MISSED)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @t=%0d: got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  task automatic adv_to(input int tgt);
    while (t < tgt) begin
      @(negedge CLK);
      t++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_si"},   32'(SI), 32'd0);
    check_val({tag, "_led"},  32'(LED_EN), 32'd0);
    check_val({tag, "_ch"},   32'(CH_IDX), 32'd0);
    check_val({tag, "_ls"},   32'(LINE_START), 32'd0);
    check_val({tag, "_gd"},   32'(GROUP_DONE), 32'd0);
    check_val({tag, "_busy"}, 32'(BUSY), 32'd0);
    check_val({tag, "_tm"},   32'(TRIG_MISSED), 32'd0);
  endtask

  initial begin
    RST = 1'b0; MODE = 2'd0; CH_MASK = 3'b111; GROUP_DELAY = 24'd0;
    EXT_START = 1'b0; EXT_LCNT = 16'd0;
    repeat (3) @(negedge CLK);
    check_all_zero("por");
    RST = 1'b1;
    t = -3;

    // continuous mode, all channels
    adv_to(-1); check_val("a_si_early", 32'(SI), 32'd0);
    adv_to(0);
    check_val("a_si0", 32'(SI), 32'd1);
    check_val("a_ls0", 32'(LINE_START), 32'd1);
    check_val("a_ch0", 32'(CH_IDX), 32'd0);
    check_val("a_led0", 32'(LED_EN), 32'd0);
    check_val("a_busy0", 32'(BUSY), 32'd1);
    check_val("a_gd0", 32'(GROUP_DONE), 32'd0);
    adv_to(2);  check_val("a_si2", 32'(SI), 32'd1);
    adv_to(3);  check_val("a_si3", 32'(SI), 32'd0);
    check_val("a_ls3", 32'(LINE_START), 32'd0);
    adv_to(9);  check_val("a_led9", 32'(LED_EN), 32'd0);
    adv_to(10); check_val("a_led10", 32'(LED_EN), 32'd1);
    adv_to(29); check_val("a_led29", 32'(LED_EN), 32'd1);
    adv_to(30); check_val("a_led30", 32'(LED_EN), 32'd0);
    adv_to(39); check_val("a_gd39", 32'(GROUP_DONE), 32'd0);
    adv_to(40);
    check_val("a_ls40", 32'(LINE_START), 32'd1);
    check_val("a_ch40", 32'(CH_IDX), 32'd1);
    check_val("a_si40", 32'(SI), 32'd1);
    adv_to(50); check_val("a_led50", 32'(LED_EN), 32'd2);
    CH_MASK = 3'b001;
    adv_to(79); check_val("b_gd79", 32'(GROUP_DONE), 32'd0);
    adv_to(80); check_val("b_ch80", 32'(CH_IDX), 32'd2);
    adv_to(90); check_val("b_led90", 32'(LED_EN), 32'd4);
    adv_to(119); check_val("b_gd119", 32'(GROUP_DONE), 32'd1);
    adv_to(120);
    check_val("b_ls120", 32'(LINE_START), 32'd1);
    check_val("b_ch120", 32'(CH_IDX), 32'd0);
    check_val("b_gd120", 32'(GROUP_DONE), 32'd0);
    adv_to(130); CH_MASK = 3'b101;
    adv_to(159); check_val("b_gd159", 32'(GROUP_DONE), 32'd1);
    adv_to(160);
    check_val("b_ch160", 32'(CH_IDX), 32'd0);
    check_val("b_ls160", 32'(LINE_START), 32'd1);
    adv_to(199); check_val("b_gd199", 32'(GROUP_DONE), 32'd0);
    adv_to(200); check_val("b_ch200", 32'(CH_IDX), 32'd2);
    adv_to(239); check_val("b_gd239", 32'(GROUP_DONE), 32'd1);
    adv_to(245); CH_MASK = 3'b000;
    adv_to(319); check_val("b_gd319", 32'(GROUP_DONE), 32'd1);
    adv_to(320); check_val("b_ch320", 32'(CH_IDX), 32'd0);
    adv_to(330); MODE = 2'd1; GROUP_DELAY = 24'd10;
    adv_to(360); check_val("b_ch360", 32'(CH_IDX), 32'd1);
    adv_to(400); check_val("b_ch400", 32'(CH_IDX), 32'd2);
    adv_to(439); check_val("b_gd439", 32'(GROUP_DONE), 32'd1);

    // burst mode: first gap clamped to LINE_TIME, then a 100-clk gap
    adv_to(440); check_val("c_ls440", 32'(LINE_START), 32'd1);
    adv_to(559); check_val("c_gd559", 32'(GROUP_DONE), 32'd1);
    adv_to(560);
    check_val("c_gap_si", 32'(SI), 32'd1);
    check_val("c_gap_ls", 32'(LINE_START), 32'd0);
    check_val("c_gap_busy", 32'(BUSY), 32'd1);
    adv_to(563); check_val("c_gap_si3", 32'(SI), 32'd0);
    adv_to(570); check_val("c_gap_led", 32'(LED_EN), 32'd0);
    adv_to(599); check_val("c_ls599", 32'(LINE_START), 32'd0);
    adv_to(600);
    check_val("c_ls600", 32'(LINE_START), 32'd1);
    check_val("c_si600", 32'(SI), 32'd1);
    check_val("c_ch600", 32'(CH_IDX), 32'd0);
    adv_to(610); GROUP_DELAY = 24'd100;
    adv_to(759); check_val("c_ls759", 32'(LINE_START), 32'd0);
    adv_to(760); check_val("c_ls760", 32'(LINE_START), 32'd1);
    adv_to(880); check_val("c_gap2_si", 32'(SI), 32'd1);
    adv_to(883); check_val("c_gap2_si3", 32'(SI), 32'd0);
    adv_to(979);
    check_val("c_ls979", 32'(LINE_START), 32'd0);
    check_val("c_busy979", 32'(BUSY), 32'd1);
    adv_to(980); check_val("c_ls980", 32'(LINE_START), 32'd1);

    // reset in the middle of an LED window
    adv_to(1000); check_val("r_led1000", 32'(LED_EN), 32'd1);
    RST = 1'b0; MODE = 2'd0;
    adv_to(1001); check_all_zero("r_mid");
    adv_to(1003); check_all_zero("r_hold");
    RST = 1'b1;
    t = -3;
    adv_to(-1); check_val("r_si_early", 32'(SI), 32'd0);
    adv_to(0);
    check_val("r_si0", 32'(SI), 32'd1);
    check_val("r_ls0", 32'(LINE_START), 32'd1);
    check_val("r_ch0", 32'(CH_IDX), 32'd0);

    // event mode
    adv_to(5); RST = 1'b0; MODE = 2'd2; EXT_LCNT = 16'd2; CH_MASK = 3'b111;
    adv_to(8); RST = 1'b1;
    t = -3;
    adv_to(2); CH_MASK = 3'b110;
    adv_to(6);
    check_val("e_idle_ch", 32'(CH_IDX), 32'd1);
    check_val("e_idle_busy", 32'(BUSY), 32'd0);
    check_val("e_idle_si", 32'(SI), 32'd0);
    CH_MASK = 3'b111;
    adv_to(10); EXT_START = 1'b1;
    adv_to(13); check_val("e_si13", 32'(SI), 32'd0);
    adv_to(14);
    check_val("e_si14", 32'(SI), 32'd1);
    check_val("e_ls14", 32'(LINE_START), 32'd1);
    check_val("e_ch14", 32'(CH_IDX), 32'd0);
    check_val("e_busy14", 32'(BUSY), 32'd1);
    adv_to(20); EXT_START = 1'b0;
    adv_to(60); EXT_START = 1'b1;
    adv_to(61); check_val("e_tm61", 32'(TRIG_MISSED), 32'd0);
    adv_to(62); check_val("e_tm62", 32'(TRIG_MISSED), 32'd1);
    adv_to(63); check_val("e_tm63", 32'(TRIG_MISSED), 32'd0);
    adv_to(70); EXT_START = 1'b0;
    adv_to(133); check_val("e_gd133", 32'(GROUP_DONE), 32'd1);
    adv_to(134);
    check_val("e_ls134", 32'(LINE_START), 32'd1);
    check_val("e_ch134", 32'(CH_IDX), 32'd0);
    adv_to(253); check_val("e_gd253", 32'(GROUP_DONE), 32'd1);
    adv_to(254);
    check_val("e_gap_si", 32'(SI), 32'd1);
    check_val("e_gap_ls", 32'(LINE_START), 32'd0);
    adv_to(264); check_val("e_gap_led", 32'(LED_EN), 32'd0);
    adv_to(293); check_val("e_busy293", 32'(BUSY), 32'd1);
    adv_to(294);
    check_val("e_busy294", 32'(BUSY), 32'd0);
    check_val("e_si294", 32'(SI), 32'd0);

    // EXT_LCNT=0 runs exactly one group
    adv_to(300); EXT_LCNT = 16'd0; EXT_START = 1'b1;
    adv_to(303); check_val("e1_si303", 32'(SI), 32'd0);
    adv_to(304);
    check_val("e1_si304", 32'(SI), 32'd1);
    check_val("e1_ls304", 32'(LINE_START), 32'd1);
    adv_to(310); EXT_START = 1'b0;
    adv_to(423); check_val("e1_gd423", 32'(GROUP_DONE), 32'd1);
    adv_to(424);
    check_val("e1_gap_ls", 32'(LINE_START), 32'd0);
    check_val("e1_gap_si", 32'(SI), 32'd1);
    adv_to(463); check_val("e1_busy463", 32'(BUSY), 32'd1);
    adv_to(464); check_val("e1_busy464", 32'(BUSY), 32'd0);

    // trigger while idle in halt mode is reported as missed
    adv_to(480); MODE = 2'd3; EXT_START = 1'b1;
    adv_to(482); check_val("h_tm482", 32'(TRIG_MISSED), 32'd1);
    adv_to(483); check_val("h_tm483", 32'(TRIG_MISSED), 32'd0);
    adv_to(490);
    check_val("h_busy", 32'(BUSY), 32'd0);
    check_val("h_si", 32'(SI), 32'd0);
    EXT_START = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cis_line_sequencer.md
# cis_line_sequencer

Parametrised line-timing sequencer for contact image sensor (CIS) front ends. It generates the sensor start pulse (SI), per-channel LED exposure windows and line/group framing strobes for N colour channels. Channels are cycled through a runtime mask, and the block supports continuous, burst and externally triggered modes. It sits between the register file and the LED PWM stage and ADC capture logic, replacing the fixed 3-colour controller.

## Interface
- NCH, 3: number of LED colour channels (1..8)
- LINE_TIME, 2688: clocks per line (0.125 us clock gives 336 us)
- PIX_CNT, 2592: clocks per LED exposure window (= sensor pixel count)
- LED_ON_START, 60: line-counter value at which the LED window opens
- SI_WIDTH, 5: SI pulse length in clocks (>=1, < LED_ON_START)
- CNT_WIDTH, 24: width of line and gap counters
- LCNT_WIDTH, 16: width of event group counter
- CLK  in  1  system clock
- RST  in  1  reset; synchronous, active-low
- MODE  in  2  0 continuous, 1 burst, 2 event, 3 halt
- CH_MASK  in  NCH  enabled channels; 0 is treated as all-ones
- GROUP_DELAY  in  CNT_WIDTH  burst gap length in clocks; clamped to min LINE_TIME
- EXT_START  in  1  event-mode trigger (level, rising edge used)
- EXT_LCNT  in  LCNT_WIDTH  groups per trigger; 0 is treated as 1
- SI  out  1  sensor start pulse
- LED_EN  out  NCH  one-hot exposure window of the current channel
- CH_IDX  out  3  index of the current channel
- LINE_START  out  1  1-clk pulse at the first clock of each line
- GROUP_DONE  out  1  1-clk pulse at the last clock of the last enabled channel line
- BUSY  out  1  high in LINE/GAP
- TRIG_MISSED  out  1  1-clk pulse when a trigger edge is ignored

## Operation
- States: IDLE, LINE, GAP. lc is the line counter (0..LINE_TIME-1). gc is the gap counter.
- Registered at group start (IDLE->LINE, or GAP->LINE, or last line -> first line): mode_q <= MODE; mask_q <= CH_MASK (or all-ones if 0); dly_q <= max(GROUP_DELAY, LINE_TIME); lcnt_q <= max(EXT_LCNT, 1). These inputs are ignored mid-group.
- LINE: SI=1 for lc in [0, SI_WIDTH-1]. LED_EN[CH_IDX]=1 for lc in [LED_ON_START, LED_ON_START+PIX_CNT-1]; all other bits are 0. LINE_START=1 at lc==0.
- At lc==LINE_TIME-1:
  - If a higher-indexed enabled channel exists, CH_IDX moves to the next enabled index and lc=0.
  - Otherwise GROUP_DONE=1 and the group ends.
- Group end by mode_q:
  - 0: restart at the lowest enabled channel immediately (no gap).
  - 1: go to GAP for dly_q clocks, then LINE.
  - 2: increment gcount. If gcount==lcnt_q, go to GAP for LINE_TIME clocks, then IDLE, and clear gcount. Otherwise start the next group back-to-back.
  - 3: go to IDLE.
- GAP: SI=1 for the first SI_WIDTH clocks of the gap (dummy flush readout); LED_EN=0 throughout.
- IDLE: SI=0 and LED_EN=0.
  - If MODE is 0 or 1, enter LINE on the next clock.
  - If MODE is 2, enter LINE on a detected EXT_START rise.
- EXT_START is registered twice: rise = q1 & ~q2.
  - A rise while BUSY or while MODE!=2 gives TRIG_MISSED=1 and is otherwise ignored.
- CH_IDX in IDLE holds the lowest enabled channel of the current CH_MASK.
- Reset (RST==0 at a clock edge): state IDLE, lc=gc=gcount=0, and all outputs 0. CH_IDX=0.
  - Mid-line reset drops SI/LED_EN on that edge, with no completion strobes.

## Timing
- All outputs are registered and change only on the CLK edge.
- After reset release in mode 0/1: SI=1 and LINE_START=1 on the 2nd edge after the first edge with RST==1.
- Event mode: EXT_START sampled high at edge k (low at k-1) gives SI=1 and LINE_START=1 after edge k+3.
- Line period is exactly LINE_TIME clocks. Group period:
  - mode 0: popcount(mask_q)*LINE_TIME
  - mode 1: popcount*LINE_TIME + dly_q
- LED window opens LED_ON_START clocks after the SI rise. It lasts PIX_CNT clocks and must close before lc wraps (LED_ON_START+PIX_CNT <= LINE_TIME; this is the user's responsibility).
- gc is CNT_WIDTH wide; dly_q up to 2^CNT_WIDTH-1 must not wrap.
- If a trigger edge and the transition to IDLE land on the same clock, the edge counts as missed.

## Test plan
- Reset, then MODE=0, CH_MASK=3'b111, small params (LINE_TIME=40, PIX_CNT=20, LED_ON_START=10, SI_WIDTH=3) -> SI high 3 clk every 40 clk; LED_EN 001,010,100 each high 20 clk starting lc=10; GROUP_DONE every 120 clk.
- MODE=0, CH_MASK=3'b101 -> channels 0,2 only; CH_IDX 0,2,0; GROUP_DONE every 80 clk; CH_MASK=0 behaves as 3'b111.
- MODE=1, GROUP_DELAY=10 (<LINE_TIME) -> 40-clk gap with 3-clk dummy SI and LED_EN=0; with GROUP_DELAY=100 -> 100-clk gap.
- MODE=2, EXT_LCNT=2, one trigger -> SI 3 edges after trigger, 2 groups back-to-back, 40-clk gap, IDLE, BUSY=0; EXT_LCNT=0 -> exactly 1 group.
- Second trigger while BUSY -> TRIG_MISSED single pulse, group count unchanged; CH_MASK change mid-group applies only at next group.
- RST low mid-LED window -> all outputs 0 on that edge, no GROUP_DONE; restart timing as after power-on.
